// File: rtl/mesm6_alu_ctl.sv
// Request/response sequencer for mesm6_alu: latches one operation, holds it stable
// while the ALU runs, returns the op to NOP, and aborts with a watchdog.
`ifndef MESM6_ALU_DEFS
`define MESM6_ALU_DEFS
`define ALU_OP_WIDTH 4
`define ALU_NOP  4'd0
`define ALU_AND  4'd1
`define ALU_OR   4'd2
`define ALU_XOR  4'd3
`define ALU_ARX  4'd4
`define ALU_ADD  4'd5
`define ALU_SUB  4'd6
`define ALU_FDIV 4'd7
`endif

module mesm6_alu_ctl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [`ALU_OP_WIDTH-1:0] req_op,
  input  logic                     req_wy,
  input  logic                     req_log,
  input  logic                     req_norm,
  input  logic                     req_round,
  input  logic [47:0]              req_a,
  input  logic [47:0]              req_b,
  output logic [`ALU_OP_WIDTH-1:0] alu_op,
  output logic                     alu_wy,
  output logic                     alu_grp_log,
  output logic                     alu_do_norm,
  output logic                     alu_do_round,
  output logic [47:0]              alu_a,
  output logic [47:0]              alu_b,
  input  logic [47:0]              alu_acc,
  input  logic                     alu_done,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [47:0]              resp_acc,
  output logic                     resp_timeout,
  output logic                     busy,
  output logic [CNT_W-1:0]         cycles
);

  typedef enum logic [1:0] {StIdle, StWy, StExec, StResp} state_e;

  state_e                   state_q, state_d;
  logic [`ALU_OP_WIDTH-1:0] op_q, op_d;
  logic                     wy_q, wy_d;
  logic                     log_q, log_d;
  logic                     norm_q, norm_d;
  logic                     round_q, round_d;
  logic [47:0]              a_q, a_d;
  logic [47:0]              b_q, b_d;
  logic                     rvalid_q, rvalid_d;
  logic [47:0]              racc_q, racc_d;
  logic                     rto_q, rto_d;
  logic [CNT_W-1:0]         cycles_q, cycles_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wy_d     = wy_q;
    log_d    = log_q;
    norm_d   = norm_q;
    round_d  = round_q;
    a_d      = a_q;
    b_d      = b_q;
    rvalid_d = rvalid_q;
    racc_d   = racc_q;
    rto_d    = rto_q;
    cycles_d = cycles_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_op == `ALU_NOP) begin
            // A plain NOP is consumed silently; only the Y-write form does anything.
            if (req_wy) begin
              a_d     = req_a;
              wy_d    = 1'b1;
              state_d = StWy;
            end
          end else begin
            op_d    = req_op;
            wy_d    = 1'b0;
            log_d   = req_log;
            norm_d  = req_norm;
            round_d = req_round;
            a_d     = req_a;
            b_d     = req_b;
            cnt_d   = '0;
            state_d = StExec;
          end
        end
      end
      StWy: begin
        wy_d    = 1'b0;
        state_d = StIdle;
      end
      StExec: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        // Done takes priority over a coincident watchdog expiry.
        if (alu_done) begin
          racc_d   = alu_acc;
          rto_d    = 1'b0;
          rvalid_d = 1'b1;
          cycles_d = cnt_q;
          op_d     = `ALU_NOP;
          state_d  = StResp;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          racc_d   = '0;
          rto_d    = 1'b1;
          rvalid_d = 1'b1;
          cycles_d = CNT_W'(TIMEOUT);
          op_d     = `ALU_NOP;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          rto_d    = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= `ALU_NOP;
      wy_q     <= 1'b0;
      log_q    <= 1'b0;
      norm_q   <= 1'b0;
      round_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rvalid_q <= 1'b0;
      racc_q   <= '0;
      rto_q    <= 1'b0;
      cycles_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wy_q     <= wy_d;
      log_q    <= log_d;
      norm_q   <= norm_d;
      round_q  <= round_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rvalid_q <= rvalid_d;
      racc_q   <= racc_d;
      rto_q    <= rto_d;
      cycles_q <= cycles_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign alu_op       = op_q;
  assign alu_wy       = wy_q;
  assign alu_grp_log  = log_q;
  assign alu_do_norm  = norm_q;
  assign alu_do_round = round_q;
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign resp_valid   = rvalid_q;
  assign resp_acc     = racc_q;
  assign resp_timeout = rto_q;
  assign cycles       = cycles_q;

endmodule
